// File: rtl/spi_config_master.sv
// SPI mode-0 initiator streaming a byte_count-byte frame; MISO capture only with SPI_MISO_CAPTURE_EN defined.
// Latency: SS/busy one cycle after start, SCLK half-period clk_div+1 cycles, done one half-period after the tail clocks.
// Backpressure: tx_ready only in LOAD; an empty tx stream parks the bus with SS low and SCLK low.
module spi_config_master #(
    parameter int CNT_W     = 10,
    parameter int TAIL_CLKS = 2
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] byte_count,
    input  logic [7:0]       clk_div,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             SCLK,
    output logic             MOSI,
    output logic             SS,
    input  logic             MISO
);
    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, TAIL, HOLD} state_t;

    localparam int            TW        = $clog2(TAIL_CLKS + 1) + 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CLKS - 1);

    state_t           state;
    logic [7:0]       div_lat;
    logic [7:0]       div_cnt;
    logic [7:0]       tx_shift;
    logic [CNT_W-1:0] bytes_left;
    logic [2:0]       bit_cnt;
    logic [TW-1:0]    tail_cnt;
    logic             tick;

    assign tick = (div_cnt == 8'd0);

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state      <= IDLE;
            SS         <= 1'b1;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_lat    <= 8'd0;
            div_cnt    <= 8'd0;
            tx_shift   <= 8'd0;
            bytes_left <= '0;
            bit_cnt    <= 3'd0;
            tail_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state inside {LOW, HIGH, TAIL, HOLD})
                div_cnt <= tick ? div_lat : div_cnt - 8'd1;
            case (state)
                IDLE: if (start) begin
                    if (byte_count != '0) begin
                        bytes_left <= byte_count;
                        div_lat    <= clk_div;
                        SS         <= 1'b0;
                        busy       <= 1'b1;
                        tx_ready   <= 1'b1;
                        state      <= LOAD;
                    end else begin
                        done <= 1'b1;
                    end
                end
                LOAD: if (tx_valid && tx_ready) begin
                    tx_shift <= tx_data;
                    MOSI     <= tx_data[7];
                    bit_cnt  <= 3'd0;
                    tx_ready <= 1'b0;
                    div_cnt  <= div_lat;
                    state    <= LOW;
                end
                LOW: if (tick) begin
                    SCLK  <= 1'b1;
                    state <= HIGH;
                end
                HIGH: if (tick) begin
                    SCLK <= 1'b0;
                    if (bit_cnt != 3'd7) begin
                        MOSI     <= tx_shift[6];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                        state    <= LOW;
                    end else begin
                        bytes_left <= bytes_left - CNT_W'(1);
                        if (bytes_left != CNT_W'(1)) begin
                            tx_ready <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            MOSI     <= 1'b0;
                            tail_cnt <= '0;
                            state    <= (TAIL_CLKS > 0) ? TAIL : HOLD;
                        end
                    end
                end
                // Tail clocks flush the slave's MOSI synchronizer; a period ends on its falling edge.
                TAIL: if (tick) begin
                    SCLK <= ~SCLK;
                    if (SCLK) begin
                        tail_cnt <= tail_cnt + TW'(1);
                        if (tail_cnt == TAIL_LAST)
                            state <= HOLD;
                    end
                end
                HOLD: if (tick) begin
                    SS    <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    logic       miso_meta;
    logic       miso_sync;
    logic [7:0] rx_shift;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
            rx_shift  <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
        end else begin
            miso_meta <= MISO;
            miso_sync <= miso_meta;
            rx_valid  <= 1'b0;
            if (state == LOW && tick)
                rx_shift <= {rx_shift[6:0], miso_sync};
            if (state == HIGH && tick && bit_cnt == 3'd7) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_shift;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = MISO;
    assign rx_data     = 8'd0;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_config_master.sv
// Directed bench for spi_config_master: vector table of frames plus hand-written reset/abort sequences.
module tb_spi_config_master;
    localparam int CNT_W = 10;

    logic             system_clock = 1'b0;
    logic             reset, start, tx_valid, MISO;
    logic [CNT_W-1:0] byte_count;
    logic [7:0]       clk_div, tx_data;
    logic             tx_ready, rx_valid, busy, done, SCLK, MOSI, SS;
    logic [7:0]       rx_data;

    int tests = 0;
    int fails = 0;

    spi_config_master #(.CNT_W(CNT_W), .TAIL_CLKS(2)) dut (
        .system_clock(system_clock), .reset(reset), .start(start),
        .byte_count(byte_count), .clk_div(clk_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
    );

    always #5 system_clock = ~system_clock;

    typedef struct {
        int         n;
        int         div;
        logic [7:0] base;
        logic [7:0] step;
        int         stall_at;
        int         stall_len;
        bit         loopback;
        int         exp_edges;
        int         exp_hs;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_cycle();
        @(posedge system_clock);
        #1;
    endtask

    function automatic logic [7:0] pat(input vec_t v, input int i);
        return v.base + 8'(i * int'(v.step));
    endfunction

    // Drives one frame cycle by cycle; samples #1 after each edge and acts as the SPI slave.
    task automatic run_frame(input vec_t v, input int abort_after);
        bit         bits[$];
        logic [7:0] rxq[$];
        int         rise_t[$];
        int idx = 0, hs = 0, stall = 0, cyc = 0, abort_cnt = 0;
        int viol_ss = 0, viol_stall = 0, bad = 0, extra_done = 0, d;
        bit pend = 0, sprev = 0, got_done = 0, ss_after = 0, busy_after = 1;
        logic [7:0] b;

        start = 1'b1; byte_count = CNT_W'(v.n); clk_div = 8'(v.div); tx_valid = 1'b0;
        tick_cycle();
        start = 1'b0;
        check("start_ss_low", SS, 0);
        check("start_busy", busy, 1);
        while (!got_done && cyc < 20000) begin
            if (pend) idx++;
            if (SCLK && !sprev) begin
                bits.push_back(MOSI);
                rise_t.push_back(cyc);
                if (SS) viol_ss++;
            end
            sprev = SCLK;
            if (rx_valid) rxq.push_back(rx_data);
            if (done) begin
                got_done = 1; ss_after = SS; busy_after = busy;
            end
            MISO  = v.loopback ? MOSI : 1'b0;
            start = (cyc == 3);
            if (idx == v.stall_at && tx_ready && stall < v.stall_len) begin
                stall++;
                tx_valid = 1'b0;
                if (SCLK || SS) viol_stall++;
            end else if (idx < v.n) begin
                tx_valid = 1'b1;
                tx_data  = pat(v, idx);
            end else begin
                tx_valid = 1'b0;
            end
            pend = tx_valid && tx_ready;
            if (pend) hs++;
            if (abort_after > 0 && idx >= abort_after) begin
                abort_cnt++;
                if (abort_cnt == 6) return;
            end
            tick_cycle();
            cyc++;
        end
        start = 1'b0; tx_valid = 1'b0;

        check("done_seen", got_done, 1);
        check("ss_high_at_done", ss_after, 1);
        check("busy_low_at_done", busy_after, 0);
        check("tx_handshakes", hs, v.exp_hs);
        check("rising_edges", bits.size(), v.exp_edges);
        check("ss_low_while_sclk", viol_ss, 0);
        if (v.stall_len > 0) begin
            check("stall_cycles", stall, v.stall_len);
            check("stall_bus_quiet", viol_stall, 0);
        end

        if (bits.size() != v.exp_edges) bad = v.n;
        else for (int i = 0; i < v.n; i++) begin
            b = 8'd0;
            for (int k = 0; k < 8; k++) b = {b[6:0], bits[8*i+k]};
            if (b != pat(v, i)) bad++;
        end
        check("slave_bytes_bad", bad, 0);
        if (bits.size() == v.exp_edges)
            check("tail_mosi_zero", int'(bits[8*v.n]) + int'(bits[8*v.n+1]), 0);

        if (rise_t.size() > 1) check("sclk_period", rise_t[1] - rise_t[0], 2 * (v.div + 1));
        bad = 0;
        for (int k = 1; k < rise_t.size(); k++) begin
            d = rise_t[k] - rise_t[k-1];
            if (k % 8 == 0 && k < 8 * v.n) begin
                if (d <= 2 * (v.div + 1)) bad++;
            end else if (d != 2 * (v.div + 1)) bad++;
        end
        check("sclk_timing_bad", bad, 0);

`ifdef SPI_MISO_CAPTURE_EN
        check("rx_count", rxq.size(), v.n);
        bad = 0;
        for (int i = 0; i < rxq.size(); i++)
            if (rxq[i] != (v.loopback ? pat(v, i) : 8'd0)) bad++;
        check("rx_bytes_bad", bad, 0);
`else
        check("rx_count_disabled", rxq.size(), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            tick_cycle();
            if (done) extra_done++;
            if (!SS) extra_done++;
        end
        check("single_done_ss_idle", extra_done, 0);
    endtask

    vec_t vecs[4];
    vec_t av;
    int   cnt;

    initial begin
        vecs[0] = '{1,   1, 8'hA5, 8'h00, 0, 0,  1'b0, 10,   1};
        vecs[1] = '{320, 0, 8'h00, 8'h01, 0, 0,  1'b0, 2562, 320};
        vecs[2] = '{2,   3, 8'h3C, 8'h87, 0, 0,  1'b1, 18,   2};
        vecs[3] = '{3,   2, 8'h11, 8'h11, 1, 20, 1'b0, 26,   3};

        reset = 1'b1; start = 1'b0; tx_valid = 1'b0; MISO = 1'b0;
        byte_count = '0; clk_div = 8'd0; tx_data = 8'd0;
        repeat (3) tick_cycle();
        check("rst_ss", SS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_done", done, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b0;
        tick_cycle();

        for (int i = 0; i < 4; i++) run_frame(vecs[i], 0);

        // Abort in the middle of the 4th byte of a 10-byte frame.
        av = '{10, 1, 8'h40, 8'h01, 0, 0, 1'b0, 82, 10};
        run_frame(av, 4);
        reset = 1'b1; tx_valid = 1'b0; start = 1'b0;
        tick_cycle();
        check("abort_ss", SS, 1);
        check("abort_sclk", SCLK, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_tx_ready", tx_ready, 0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick_cycle();
            if (done) cnt++;
        end
        check("abort_no_done", cnt, 0);

        start = 1'b1; byte_count = '0; clk_div = 8'd2;
        tick_cycle();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_ss", SS, 1);
        check("zero_busy", busy, 0);
        tick_cycle();
        check("zero_done_one_cycle", done, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (!SS || SCLK) cnt++;
            tick_cycle();
        end
        check("zero_bus_idle", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_config_master.md
Name: spi_config_master

Overview:
- SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first) that streams an N-byte configuration frame into the network's SPI slave port.
- Used by the on-board loader and in the system testbench to drive SCLK/MOSI/SS and capture MISO.
- Bytes arrive on a valid/ready stream, so a full 320-byte frame needs no buffer.
- Runs entirely in the system_clock domain. SCLK is a generated, divided, registered output.

Parameters:
- CNT_W, 10, width of byte_count; max frame = 2^CNT_W-1 bytes.
- TAIL_CLKS, 2, extra SCLK pulses (MOSI=0) after the last byte. These flush the slave's SCLK-domain MOSI synchronizer.

Ports:
- system_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- byte_count  in  CNT_W  frame length; sampled with start.
- clk_div  in  8  SCLK half-period = clk_div+1 system_clock cycles; sampled with start.
- tx_data  in  8  next byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  master accepts tx_data this cycle.
- rx_data  out  8  byte shifted in from MISO.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- SCLK  out  1  SPI clock, idles low.
- MOSI  out  1  SPI data out.
- SS  out  1  active-low slave select.
- MISO  in  1  SPI data in; 2-flop synchronized to system_clock before use.

Behaviour:
- Reset (sync): SS=1, SCLK=0, MOSI=0, tx_ready=0, rx_valid=0, done=0, busy=0, rx_data=0; state=IDLE. Reset asserted mid-frame aborts on the next edge. No done pulse is issued for an aborted frame.
- Half-period tick: counter reloads to clk_div; a tick fires when it reaches 0. The counter runs only in LOW, HIGH, TAIL and HOLD.
- IDLE
  - start with byte_count!=0: latch count and clk_div; SS=0 and busy=1 next cycle; go to LOAD.
  - start with byte_count==0: done=1 for one cycle next cycle; SS never asserts.
  - start while busy: ignored.
- LOAD
  - tx_ready=1, SCLK=0.
  - On tx_valid&tx_ready: shift register <= tx_data, MOSI <= tx_data[7], bit counter=0; go to LOW.
  - tx_valid low: stall indefinitely with SS low and SCLK low (legal underrun).
- LOW: on tick, SCLK<=1, shift synchronized MISO into the rx register; go to HIGH.
- HIGH: on tick, SCLK<=0.
  - bit<7: MOSI<=next bit, bit++, go to LOW.
  - bit==7: rx_valid pulse with rx_data; bytes_left--.
    - bytes_left!=0: go to LOAD.
    - else TAIL_CLKS>0: go to TAIL.
    - else: go to HOLD.
- TAIL: TAIL_CLKS full SCLK periods with MOSI=0; MISO is ignored. Then go to HOLD.
- HOLD: one half-period with SCLK=0 and SS=0. Then SS<=1, busy<=0, done pulse, return to IDLE.
- Timing invariants:
  - MOSI changes only on SCLK falling edges or in LOAD, so it is stable at least clk_div+1 cycles before each rising edge.
  - SCLK period is 2*(clk_div+1) cycles within a byte.
  - The gap between bytes is at least 1 extra cycle with SCLK low.
- Counting: rising edges per frame = 8*byte_count + TAIL_CLKS. The byte counter never wraps because zero is handled in IDLE.

Optional Feature:
- SPI_MISO_CAPTURE_EN
  - Defined: MISO synchronizer, rx shift register, rx_data and rx_valid are implemented as described.
  - Undefined: MISO is unused, rx_data is tied to 0, rx_valid is tied to 0. All other timing is unchanged.

Test Plan:
- Reset asserted 3 cycles: outputs must read SS=1, SCLK=0, MOSI=0, busy=0, tx_ready=0, done=0.
- clk_div=1, byte_count=1, tx_data=8'hA5 held valid:
  - SCLK period must be 4 cycles.
  - MOSI sampled at rising edges must read 1,0,1,0,0,1,0,1, followed by 2 tail edges with MOSI=0.
  - done must pulse once; SS must return high.
- byte_count=320, clk_div=0, incrementing bytes streamed: exactly 2562 rising edges, 320 tx handshakes, one done. A slave model must reconstruct all 320 bytes.
- With SPI_MISO_CAPTURE_EN, MISO looped to MOSI, bytes 8'h3C then 8'hC3: rx_valid must pulse twice with rx_data 8'h3C then 8'hC3.
- tx_valid dropped for 20 cycles before byte 2: SCLK must stay low and SS low with no extra edges; the frame must resume correctly.
- Reset mid-byte 4 of 10: next cycle SS=1, SCLK=0, busy=0, no done. Then start with byte_count=0: done must pulse next cycle and SS must stay high.
